// File: rtl/dcache_access_ctrl_pkg.sv
// Shared definitions for the data-cache access controller:
// opcodes and the 3-bit FSM state encoding.
package dcache_access_ctrl_pkg;

    localparam logic [5:0] OP_LW = 6'd5;
    localparam logic [5:0] OP_SW = 6'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_access_ctrl_strobe_timer.sv
// Phase timer: counts 0..last while enabled, raises done on
// the final count and clears itself for the next phase.
module dcache_access_ctrl_strobe_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = en && (cnt == last);

    always_ff @(posedge clk) begin
        if (reset || !en || done)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/dcache_access_ctrl.sv
// Strobe-driven data-memory initiator for lw/sw requests.
// Optional ACCESS_COUNT_EN adds rd_count/wr_count outputs.
module dcache_access_ctrl
    import dcache_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STROBE_CYC = 1,
    parameter int SETTLE_CYC = 1
`ifdef ACCESS_COUNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ACCESS_COUNT_EN
    ,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
`endif
);

    localparam int TMAX = (STROBE_CYC > SETTLE_CYC) ? STROBE_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    state_t        state_q, state_n;
    logic          is_sw_q;
    logic          op_lw, op_sw, accept;
    logic          tmr_en, tmr_done;
    logic [TW-1:0] tmr_last;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        op_lw = 1'b0;
        op_sw = 1'b0;
        unique case (1'b1)
            (req_opcode == OP_LW): op_lw = 1'b1;
            (req_opcode == OP_SW): op_sw = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state_q;
        tmr_en   = 1'b0;
        tmr_last = '0;
        unique case (state_q)
            S_IDLE:
                if (accept)
                    state_n = (op_lw || op_sw) ? S_SETUP : S_RESP;
            S_SETUP:
                state_n = S_STROBE;
            S_STROBE: begin
                tmr_en   = 1'b1;
                tmr_last = TW'(STROBE_CYC - 1);
                if (tmr_done) state_n = S_HOLD;
            end
            S_HOLD: begin
                tmr_en   = 1'b1;
                tmr_last = TW'(SETTLE_CYC - 1);
                if (tmr_done) state_n = S_RESP;
            end
            S_RESP:
                if (resp_valid && resp_ready) state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    dcache_access_ctrl_strobe_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (tmr_en),
        .last  (tmr_last),
        .done  (tmr_done)
    );

    // Strobes are decoded from the next state so they leave a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_sw_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_n;
            resp_valid <= (state_n == S_RESP);
            mem_read   <= (state_n == S_STROBE) && !is_sw_q;
            mem_write  <= (state_n == S_STROBE) && is_sw_q;
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= op_sw ? req_wdata : '0;
                is_sw_q   <= op_sw;
                resp_err  <= !(op_lw || op_sw);
                resp_data <= '0;
            end
            if (state_q == S_HOLD && tmr_done && !is_sw_q)
                resp_data <= mem_rdata;
        end
    end

`ifdef ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state_q == S_SETUP) begin
            if (is_sw_q) wr_count <= wr_count + CNT_W'(1);
            else         rd_count <= rd_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_dcache_access_ctrl;

    localparam int S = 1;
    localparam int T = 1;
    localparam int L = 1 + S + T;
    localparam logic [5:0] LW = 6'd5;
    localparam logic [5:0] SW = 6'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ACCESS_COUNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ACCESS_COUNT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    // Memory behind the strobes: 16 words, word 3 preloaded to all ones.
    logic [31:0] mem     [16];
    logic [31:0] mdl_mem [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h0101_0101 * i;
            mdl_mem[i] = 32'h0101_0101 * i;
        end
        mem[3]     = 32'hFFFF_FFFF;
        mdl_mem[3] = 32'hFFFF_FFFF;
        mem_rdata  = '0;
    end

    always @(posedge mem_write) mem[mem_addr[3:0]] = mem_wdata;
    always @(posedge mem_read)  mem_rdata = mem[mem_addr[3:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = idle, 1 = access in flight (t edges since accept), 2 = responding.
    int          ph = 0;
    int          t = 0;
    bit          live = 0;
    bit          m_sw, m_lw;
    logic [31:0] m_addr, m_wdata, e_data;
    logic        e_err;
    int          m_rd = 0, m_wr = 0;

    always @(posedge clk) begin
        if (reset) begin
            ph = 0; t = 0; live = 1;
            m_addr = '0; m_wdata = '0;
            m_rd = 0; m_wr = 0;
        end else if (live) begin
            case (ph)
                0: if (req_valid) begin
                    m_lw    = (req_opcode == LW);
                    m_sw    = (req_opcode == SW);
                    m_addr  = req_addr;
                    m_wdata = m_sw ? req_wdata : '0;
                    t = 0;
                    if (m_lw || m_sw) ph = 1;
                    else begin ph = 2; e_err = 1'b1; e_data = '0; end
                end
                1: begin
                    t++;
                    if (t == 1) begin
                        if (m_sw) begin
                            mdl_mem[m_addr[3:0]] = m_wdata;
                            m_wr = (m_wr + 1) % 65536;
                        end else m_rd = (m_rd + 1) % 65536;
                    end
                    if (t == L) begin
                        ph = 2; e_err = 1'b0;
                        e_data = m_lw ? mdl_mem[m_addr[3:0]] : '0;
                    end
                end
                default: if (resp_ready) ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("req_ready", 32'(req_ready), 32'(ph == 0));
            chk("resp_valid", 32'(resp_valid), 32'(ph == 2));
            chk("mem_read", 32'(mem_read), 32'(ph == 1 && m_lw && t >= 1 && t <= S));
            chk("mem_write", 32'(mem_write), 32'(ph == 1 && m_sw && t >= 1 && t <= S));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            if (ph == 2) begin
                chk("resp_data", resp_data, e_data);
                chk("resp_err", 32'(resp_err), 32'(e_err));
            end
`ifdef ACCESS_COUNT_EN
            chk("rd_count", 32'(rd_count), 32'(m_rd));
            chk("wr_count", 32'(wr_count), 32'(m_wr));
`endif
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout req_ready stuck 0 want 1");
        end
        req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_resp();
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [3:0] rp, vp;
    int         n;

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_opcode = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // 1: reset state
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        chk("t1_resp_valid", 32'(resp_valid), 32'd0);
        chk("t1_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("t1_mem_addr", mem_addr, 32'd0);

        // 2: lw from preloaded word 3
        issue(LW, 32'd3, 32'hDEAD_BEEF);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rp[k] = mem_read; vp[k] = resp_valid; n += int'(mem_write);
        end
        chk("t2_read_pattern", 32'(rp), 32'b0010);
        chk("t2_valid_pattern", 32'(vp), 32'b1000);
        chk("t2_no_write", 32'(n), 32'd0);
        chk("t2_data", resp_data, 32'hFFFF_FFFF);
        chk("t2_err", 32'(resp_err), 32'd0);
        finish_resp();

        // 3: store then load back
        issue(SW, 32'd5, 32'h1234_5678);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n += int'(mem_write);
        end
        chk("t3_write_pulses", 32'(n), 32'd1);
        chk("t3_sw_data", resp_data, 32'd0);
        finish_resp();
        issue(LW, 32'd5, 32'd0);
        repeat (4) @(negedge clk);
        chk("t3_load", resp_data, 32'h1234_5678);
        finish_resp();
`ifdef ACCESS_COUNT_EN
        chk("t3_rd_count", 32'(rd_count), 32'd2);
        chk("t3_wr_count", 32'(wr_count), 32'd1);
`endif

        // 4: illegal opcode
        issue(6'd1, 32'd7, 32'd0);
        @(negedge clk);
        chk("t4_valid", 32'(resp_valid), 32'd1);
        chk("t4_err", 32'(resp_err), 32'd1);
        chk("t4_data", resp_data, 32'd0);
        chk("t4_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        finish_resp();

        // 5: back-pressure with req_valid held high
        issue(LW, 32'd3, 32'd0);
        req_valid = 1'b1;
        repeat (4) @(negedge clk);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n += int'(mem_read) + int'(!resp_valid) + int'(req_ready);
            n += int'(resp_data != 32'hFFFF_FFFF);
        end
        chk("t5_stall_faults", 32'(n), 32'd0);
        req_valid = 1'b0;
        finish_resp();

        // 6: reset while mem_read is high
        issue(LW, 32'd3, 32'd0);
        repeat (2) @(negedge clk);
        chk("t6_read_high", 32'(mem_read), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("t6_no_resp", 32'(resp_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        #1 reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(resp_valid);
        end
        chk("t6_quiet", 32'(n), 32'd0);
        #1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            req_valid  = ($urandom_range(0, 2) != 0);
            req_opcode = (r < 3) ? LW : (r < 6) ? SW : 6'($urandom_range(0, 63));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            resp_ready = $urandom_range(0, 1) == 1;
            reset      = ($urandom_range(0, 96) == 0);
            @(negedge clk); #1;
        end
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
